// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MIPS load/store unit driving a word-addressed data memory port
//
// Purpose:
//   Accepts LB/LBU/LH/LHU/LW/SB/SH/SW requests over a valid/ready handshake
//   and drives a word-addressed memory with combinational read data.
//   Loads pick a big-endian byte or halfword lane and sign/zero extend it.
//   Sub-word stores read the word, merge the new lane(s) and write it back.
//   Misaligned halfword/word accesses are answered with a fault response
//   without any memory access.
//
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   req_valid / req_ready       request handshake (ready only in IDLE)
//   req_op, req_addr, req_wdata operation, byte address, right-aligned store data
//   resp_valid                  one-cycle completion pulse per accepted request
//   resp_rdata                  load result (0 for stores and faults)
//   resp_misaligned             alignment fault flag, qualifies resp_valid
//   data_mem_write              memory write strobe (WRITE state only)
//   data_address                memory word address (latched byte address / 4)
//   data_write_data             memory write data (0 outside WRITE)
//   data_read_data              memory read data, combinational from data_address

module load_store_unit #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [ADDR_BITS+1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_misaligned,
  output logic                 data_mem_write,
  output logic [ADDR_BITS-1:0] data_address,
  output logic [WORD_SIZE-1:0] data_write_data,
  input  logic [WORD_SIZE-1:0] data_read_data
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MERGE,
    S_WRITE
  } state_t;

  state_t state;
  state_t next_state;

  // Request fields captured at acceptance. Only the low halfword of the
  // store data is kept: SW bypasses this register straight into wbuf.
  logic [2:0]           op_q;
  logic [ADDR_BITS+1:0] addr_q;
  logic [15:0]          wdata_q;
  logic [WORD_SIZE-1:0] wbuf;

  logic                 req_is_load;
  logic                 req_is_half;
  logic                 req_is_word;
  logic                 req_fault;

  logic [7:0]           lane_byte;
  logic [15:0]          lane_half;
  logic [WORD_SIZE-1:0] load_value;
  logic [WORD_SIZE-1:0] merge_value;

  // Request decode, evaluated on the live request inputs in IDLE.
  always_comb begin
    req_is_load = (req_op == OP_LB) || (req_op == OP_LH) || (req_op == OP_LW) ||
                  (req_op == OP_LBU) || (req_op == OP_LHU);
    req_is_half = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
    req_is_word = (req_op == OP_LW) || (req_op == OP_SW);
    req_fault   = (req_is_half && req_addr[0]) ||
                  (req_is_word && (req_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    req_ready      = 1'b0;
    data_mem_write = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        // Faulting requests are answered from IDLE and never leave it.
        if (req_valid && !req_fault) begin
          if (req_is_load) begin
            next_state = S_LOAD;
          end else if (req_op == OP_SW) begin
            next_state = S_WRITE;
          end else begin
            next_state = S_MERGE;
          end
        end
      end
      S_LOAD: begin
        next_state = S_IDLE;
      end
      S_MERGE: begin
        next_state = S_WRITE;
      end
      S_WRITE: begin
        // Decoded from state so an asynchronous reset drops it at once.
        data_mem_write = 1'b1;
        next_state     = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign data_address    = addr_q[ADDR_BITS+1:2];
  assign data_write_data = data_mem_write ? wbuf : '0;

  // Big-endian lane selection: byte offset 0 is the most significant byte.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_byte = data_read_data[WORD_SIZE-1  -: 8];
      2'd1:    lane_byte = data_read_data[WORD_SIZE-9  -: 8];
      2'd2:    lane_byte = data_read_data[WORD_SIZE-17 -: 8];
      default: lane_byte = data_read_data[WORD_SIZE-25 -: 8];
    endcase
    lane_half = addr_q[1] ? data_read_data[15:0] : data_read_data[WORD_SIZE-1 -: 16];

    case (op_q)
      OP_LB:   load_value = {{(WORD_SIZE-8){lane_byte[7]}}, lane_byte};
      OP_LBU:  load_value = {{(WORD_SIZE-8){1'b0}}, lane_byte};
      OP_LH:   load_value = {{(WORD_SIZE-16){lane_half[15]}}, lane_half};
      OP_LHU:  load_value = {{(WORD_SIZE-16){1'b0}}, lane_half};
      default: load_value = data_read_data;
    endcase
  end

  // Read-modify-write merge: keep the memory word, overwrite the addressed
  // lane(s) with the right-aligned store data.
  always_comb begin
    merge_value = data_read_data;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0:    merge_value[WORD_SIZE-1  -: 8] = wdata_q[7:0];
        2'd1:    merge_value[WORD_SIZE-9  -: 8] = wdata_q[7:0];
        2'd2:    merge_value[WORD_SIZE-17 -: 8] = wdata_q[7:0];
        default: merge_value[WORD_SIZE-25 -: 8] = wdata_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) begin
        merge_value[15:0] = wdata_q;
      end else begin
        merge_value[WORD_SIZE-1 -: 16] = wdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q            <= 3'b000;
      addr_q          <= '0;
      wdata_q         <= 16'h0000;
      wbuf            <= '0;
      resp_valid      <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_rdata      <= '0;
    end else begin
      // Response outputs are pulses; they fall back to zero unless set below.
      resp_valid      <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_rdata      <= '0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata[15:0];
            if (req_fault) begin
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
            end else if (req_op == OP_SW) begin
              wbuf <= req_wdata;
            end
          end
        end
        S_LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_value;
        end
        S_MERGE: begin
          wbuf <= merge_value;
        end
        S_WRITE: begin
          resp_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        data_mem_write;
  logic [7:0]  data_address;
  logic [31:0] data_write_data;
  logic [31:0] data_read_data;

  load_store_unit #(.WORD_SIZE(32), .ADDR_BITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned),
    .data_mem_write(data_mem_write),
    .data_address(data_address),
    .data_write_data(data_write_data),
    .data_read_data(data_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory seen by the DUT.
  logic [31:0] mem [256];
  assign data_read_data = mem[data_address];
  always @(posedge clk) if (data_mem_write) mem[data_address] <= data_write_data;

  // Reference model state.
  logic [31:0] ref_mem [256];
  typedef struct { int due; logic [31:0] rdata; logic mis; } resp_t;
  typedef struct { int due; logic [7:0] a; logic [31:0] d; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];
  logic [31:0] resp_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int acc_count = 0;
  int last_acc_cyc = 0;
  logic [7:0]  last_wr_addr = 8'h00;
  logic [31:0] last_wr_data = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: derive the response and memory effect of a request from the
  // ISA rules with plain shifts and masks.
  task automatic model_accept(input logic [2:0] op, input logic [9:0] a, input logic [31:0] w);
    logic [31:0] word, res;
    int off, sh;
    logic mis;
    resp_t r;
    wr_t wr;
    off  = int'(a[1:0]);
    word = ref_mem[a[9:2]];
    mis  = ((op == 3'd1 || op == 3'd4 || op == 3'd6) && a[0]) ||
           ((op == 3'd2 || op == 3'd7) && (a[1:0] != 2'b00));
    r.mis   = mis;
    r.rdata = 32'h0;
    if (mis) begin
      r.due = cyc + 1;
    end else if (op < 3'd5) begin
      r.due = cyc + 2;
      case (op)
        3'd0, 3'd3: begin
          res = (word >> (8 * (3 - off))) & 32'hFF;
          if (op == 3'd0 && res[7]) res = res | 32'hFFFFFF00;
        end
        3'd1, 3'd4: begin
          res = (word >> (8 * (2 - off))) & 32'hFFFF;
          if (op == 3'd1 && res[15]) res = res | 32'hFFFF0000;
        end
        default: res = word;
      endcase
      r.rdata = res;
    end else begin
      wr.a = a[9:2];
      if (op == 3'd7) begin
        wr.d   = w;
        wr.due = cyc + 1;
      end else if (op == 3'd5) begin
        sh     = 8 * (3 - off);
        wr.d   = (word & ~(32'hFF << sh)) | ((w & 32'hFF) << sh);
        wr.due = cyc + 2;
      end else begin
        sh     = 8 * (2 - off);
        wr.d   = (word & ~(32'hFFFF << sh)) | ((w & 32'hFFFF) << sh);
        wr.due = cyc + 2;
      end
      r.due = wr.due + 1;
      wr_q.push_back(wr);
    end
    resp_q.push_back(r);
  endtask

  // Scoreboard: every cycle out of reset, compare write port and response
  // against what the model has scheduled for this cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (data_mem_write) begin
        wr_count++;
        last_wr_addr = data_address;
        last_wr_data = data_write_data;
      end
      if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
        chk("sb_write_strobe", data_mem_write, 1'b1);
        chk("sb_write_addr", data_address, wr_q[0].a);
        chk("sb_write_data", data_write_data, wr_q[0].d);
        ref_mem[wr_q[0].a] = wr_q[0].d;
        void'(wr_q.pop_front());
      end else begin
        chk("sb_no_write", data_mem_write, 1'b0);
      end
      if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
        chk("sb_resp_valid", resp_valid, 1'b1);
        chk("sb_resp_rdata", resp_rdata, resp_q[0].rdata);
        chk("sb_resp_mis", resp_misaligned, resp_q[0].mis);
        void'(resp_q.pop_front());
      end else begin
        chk("sb_no_resp", resp_valid, 1'b0);
      end
      if (resp_valid) resp_log.push_back(resp_rdata);
      if (req_valid && req_ready) begin
        acc_count++;
        last_acc_cyc = cyc;
        model_accept(req_op, req_addr, req_wdata);
      end
    end
    cyc++;
  end

  // Waits until the request is accepted; returns just after the accept edge.
  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout actual=not_ready expected=ready at %0t", $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [9:0] a, input logic [31:0] w,
                      input logic [31:0] er, input logic em, input int elat);
    int lat;
    @(posedge clk);
    #1;
    req_op = op; req_addr = a; req_wdata = w; req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 10);
    chk("lit_resp_seen", resp_valid, 1'b1);
    chk("lit_latency", lat, elat);
    chk("lit_rdata", resp_rdata, er);
    chk("lit_mis", resp_misaligned, em);
  endtask

  int wr_before;
  int first_acc;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[5]  = 32'h8899AABB;
    mem[6]  = 32'h7F0180FF;
    mem[8]  = 32'h0BADF00D;
    mem[9]  = 32'h11223344;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    rst = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 10'h0; req_wdata = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_mis", resp_misaligned, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_write", data_mem_write, 1'b0);
    chk("rst_address", data_address, 8'h00);
    chk("rst_write_data", data_write_data, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Loads from word 5.
    send(3'd0, 10'h015, 32'h0, 32'hFFFFFF99, 1'b0, 2);
    send(3'd3, 10'h015, 32'h0, 32'h00000099, 1'b0, 2);
    send(3'd1, 10'h014, 32'h0, 32'hFFFF8899, 1'b0, 2);
    send(3'd4, 10'h016, 32'h0, 32'h0000AABB, 1'b0, 2);
    send(3'd2, 10'h014, 32'h0, 32'h8899AABB, 1'b0, 2);
    chk("no_write_on_loads", wr_count, 0);

    // Byte store via read-modify-write.
    send(3'd5, 10'h017, 32'h123456CC, 32'h0, 1'b0, 3);
    chk("sb_write_count", wr_count, 1);
    chk("sb_write_addr_lit", last_wr_addr, 8'h05);
    chk("sb_write_data_lit", last_wr_data, 32'h8899AACC);
    send(3'd2, 10'h014, 32'h0, 32'h8899AACC, 1'b0, 2);

    // Misaligned accesses.
    send(3'd2, 10'h016, 32'h0, 32'h0, 1'b1, 1);
    send(3'd6, 10'h015, 32'hFFFF, 32'h0, 1'b1, 1);
    send(3'd4, 10'h019, 32'h0, 32'h0, 1'b1, 1);
    send(3'd7, 10'h01B, 32'h1, 32'h0, 1'b1, 1);
    chk("fault_no_write", wr_count, 1);
    chk("fault_word5_kept", mem[5], 32'h8899AACC);

    // Halfword store, then more lane/extension cases on word 6.
    send(3'd6, 10'h016, 32'hABCD1234, 32'h0, 1'b0, 3);
    send(3'd2, 10'h014, 32'h0, 32'h88991234, 1'b0, 2);
    send(3'd0, 10'h018, 32'h0, 32'h0000007F, 1'b0, 2);
    send(3'd0, 10'h01B, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    send(3'd1, 10'h01A, 32'h0, 32'hFFFF80FF, 1'b0, 2);
    send(3'd4, 10'h018, 32'h0, 32'h00007F01, 1'b0, 2);
    send(3'd3, 10'h01A, 32'h0, 32'h00000080, 1'b0, 2);
    send(3'd7, 10'h018, 32'h01020304, 32'h0, 1'b0, 2);
    send(3'd2, 10'h018, 32'h0, 32'h01020304, 1'b0, 2);

    // Back-to-back LW then SW with req_valid held high.
    @(posedge clk); #1;
    req_op = 3'd2; req_addr = 10'h024; req_wdata = 32'h0; req_valid = 1'b1;
    wait_accept();
    first_acc = last_acc_cyc;
    req_op = 3'd7; req_wdata = 32'hCAFEF00D;
    wait_accept();
    req_valid = 1'b0;
    chk("b2b_accept_gap", last_acc_cyc - first_acc, 2);
    repeat (4) @(negedge clk);
    chk("b2b_word9", mem[9], 32'hCAFEF00D);
    chk("b2b_lw_rdata", resp_log[resp_log.size()-2], 32'h11223344);

    // Store immediately followed by a load of the same word.
    @(posedge clk); #1;
    req_op = 3'd7; req_addr = 10'h028; req_wdata = 32'h55667788; req_valid = 1'b1;
    wait_accept();
    req_op = 3'd2; req_wdata = 32'h0;
    wait_accept();
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("st_ld_forward", resp_log[resp_log.size()-1], 32'h55667788);

    // Reset during WRITE of SW to word 8.
    wr_before = wr_count;
    @(posedge clk); #1;
    req_op = 3'd7; req_addr = 10'h020; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0;
    chk("rst_mid_write_before", data_mem_write, 1'b1);
    #2;
    rst = 1'b0;
    resp_q.delete();
    wr_q.delete();
    #1;
    chk("rst_mid_write_drop", data_mem_write, 1'b0);
    chk("rst_mid_wdata", data_write_data, 32'h0);
    chk("rst_mid_resp", resp_valid, 1'b0);
    chk("rst_mid_ready", req_ready, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_mid_word8", mem[8], 32'h0BADF00D);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_after_ready", req_ready, 1'b1);
    chk("rst_no_write", wr_count, wr_before);
    send(3'd2, 10'h020, 32'h0, 32'h0BADF00D, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("sb_resp_drained", resp_q.size(), 0);
    chk("sb_write_drained", wr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
